// File: rtl/param_locker_if.sv
// Keypad-side handshake and status bundle for param_locker.
// The master is the debouncer/front end; the slave is the locker itself.
interface param_locker_if #(
  parameter int DIGITS = 4,
  parameter int CODE_W = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CODE_W-1:0] Code;
  logic              Code_valid;
  logic              Start;
  logic              Mode;
  logic              Lock;
  logic              Unlock;
  logic              Err;
  logic              alert;
  logic [3:0]        state_code;
  logic [IW-1:0]     digit_idx;

  modport master (
    output Code, Code_valid, Start, Mode, Lock,
    input  Unlock, Err, alert, state_code, digit_idx
  );

  modport slave (
    input  Code, Code_valid, Start, Mode, Lock,
    output Unlock, Err, alert, state_code, digit_idx
  );
endinterface

// File: rtl/param_locker.sv
// Parametrised serial code lock: N-digit user/admin password check with
// retry lockout, inactivity timeout, relock and unlock-gated password change.
module param_locker #(
  parameter int DIGITS    = 4,
  parameter int CODE_W    = 4,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 16,
  parameter logic [DIGITS*CODE_W-1:0] ADMIN_PW     = 16'h0207,
  parameter logic [DIGITS*CODE_W-1:0] USER_DEFAULT = 16'h0103
) (
  input logic           CLK,
  input logic           RST,
  param_locker_if.slave bus
);

  localparam int PW_W = DIGITS * CODE_W;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW   = $clog2(MAX_TRIES + 1);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_TRIES);
  localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VERIFY = 2'd1,
    SET    = 2'd2,
    OPEN   = 2'd3
  } state_t;

  state_t          state;
  logic            unlock_q;
  logic            err_q;
  logic            alert_q;
  logic            mismatch;
  logic [FW-1:0]   fail_cnt;
  logic [PW_W-1:0] user_pw;
  logic [PW_W-1:0] shadow;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   idle_cnt;

  int unsigned     bit_pos;
  logic [CODE_W-1:0] ref_digit;
  logic            mism_next;
  logic [PW_W-1:0] shadow_next;
  logic            last_digit;
  logic            timed_out;
  logic [FW-1:0]   fail_inc;
  logic [FW-1:0]   fail_cnt_f;
  logic            alert_f;

  // Digit 0 sits in the MSBs, so the slice for digit idx counts down from the top.
  always_comb begin
    bit_pos     = 32'(unsigned'((DIGITS - 1 - int'(idx)) * CODE_W));
    ref_digit   = alert_q ? ADMIN_PW[bit_pos +: CODE_W] : user_pw[bit_pos +: CODE_W];
    mism_next   = mismatch | (bus.Code != ref_digit);
    shadow_next = shadow;
    shadow_next[bit_pos +: CODE_W] = bus.Code;
    last_digit  = (idx == LAST_IDX);
    timed_out   = (TIMEOUT != 0) && !bus.Code_valid && (idle_cnt == IDLE_LAST);
    fail_inc    = (fail_cnt < FAIL_MAX) ? fail_cnt + 1'b1 : fail_cnt;
    // Admin-mode failures leave the saturated count and the lockout alone.
    fail_cnt_f  = alert_q ? fail_cnt : fail_inc;
    alert_f     = alert_q | (fail_inc == FAIL_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      unlock_q <= 1'b0;
      err_q    <= 1'b0;
      alert_q  <= 1'b0;
      mismatch <= 1'b0;
      fail_cnt <= '0;
      user_pw  <= USER_DEFAULT;
      shadow   <= '0;
      idx      <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start && bus.Mode) begin
            state    <= VERIFY;
            err_q    <= 1'b0;
            idx      <= '0;
            mismatch <= 1'b0;
            idle_cnt <= '0;
          end
        end

        VERIFY: begin
          if (bus.Code_valid) begin
            idle_cnt <= '0;
            if (last_digit) begin
              idx      <= '0;
              mismatch <= 1'b0;
              if (!mism_next) begin
                state    <= OPEN;
                unlock_q <= 1'b1;
                err_q    <= 1'b0;
                fail_cnt <= '0;
                if (alert_q) begin
                  alert_q <= 1'b0;
                  user_pw <= USER_DEFAULT;
                end
              end else begin
                state    <= IDLE;
                err_q    <= 1'b1;
                fail_cnt <= fail_cnt_f;
                alert_q  <= alert_f;
              end
            end else begin
              idx      <= idx + 1'b1;
              mismatch <= mism_next;
            end
          end else if (timed_out) begin
            state    <= IDLE;
            err_q    <= 1'b1;
            idx      <= '0;
            mismatch <= 1'b0;
            idle_cnt <= '0;
            fail_cnt <= fail_cnt_f;
            alert_q  <= alert_f;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        SET: begin
          if (bus.Code_valid) begin
            idle_cnt <= '0;
            if (last_digit) begin
              // Final digit is merged on the fly so user_pw updates atomically.
              user_pw  <= shadow_next;
              shadow   <= '0;
              state    <= IDLE;
              unlock_q <= 1'b0;
              err_q    <= 1'b0;
              idx      <= '0;
            end else begin
              shadow <= shadow_next;
              idx    <= idx + 1'b1;
            end
          end else if (timed_out) begin
            state    <= IDLE;
            unlock_q <= 1'b0;
            err_q    <= 1'b1;
            idx      <= '0;
            shadow   <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        OPEN: begin
          if (bus.Lock) begin
            state    <= IDLE;
            unlock_q <= 1'b0;
          end else if (bus.Start && !bus.Mode) begin
            state    <= SET;
            idx      <= '0;
            idle_cnt <= '0;
            shadow   <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Unlock     = unlock_q;
  assign bus.Err        = err_q;
  assign bus.alert      = alert_q;
  assign bus.state_code = {2'b00, state};
  assign bus.digit_idx  = idx;

endmodule

// File: tb/tb_param_locker.sv
module tb_param_locker;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  param_locker_if #(.DIGITS(4), .CODE_W(4)) ifa ();
  param_locker_if #(.DIGITS(6), .CODE_W(3)) ifb ();

  param_locker #(
    .DIGITS(4), .CODE_W(4), .MAX_TRIES(3), .TIMEOUT(16),
    .ADMIN_PW(16'h0207), .USER_DEFAULT(16'h0103)
  ) dut_a (.CLK(clk), .RST(rst_a), .bus(ifa));

  param_locker #(
    .DIGITS(6), .CODE_W(3), .MAX_TRIES(1), .TIMEOUT(16),
    .ADMIN_PW({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2}),
    .USER_DEFAULT({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6})
  ) dut_b (.CLK(clk), .RST(rst_b), .bus(ifb));

  typedef struct {
    bit       sel;
    bit       rst, start, mode, cv;
    bit [3:0] code;
    bit       lock;
    bit       unl, err, alr;
    bit [3:0] st;
    bit [2:0] idx;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   rst_mark = -1;
  int   to_mark  = -1;

  function automatic void add(bit sel, bit rst, bit start, bit mode, bit cv, int code,
                              bit lock, bit unl, bit err, bit alr, int st, int idx);
    vec_t v;
    v.sel = sel; v.rst = rst; v.start = start; v.mode = mode; v.cv = cv;
    v.code = 4'(code); v.lock = lock;
    v.unl = unl; v.err = err; v.alr = alr; v.st = 4'(st); v.idx = 3'(idx);
    vecs.push_back(v);
  endfunction

  function automatic void ent(bit sel, int n, int unsigned digs, bit unl, bit alr, int st,
                              bit f_unl, bit f_err, bit f_alr, int f_st);
    for (int i = 0; i < n; i++) begin
      int d;
      d = int'((digs >> (4 * (n - 1 - i))) & 32'hF);
      if (i < n - 1) add(sel, 0, 0, 0, 1, d, 0, unl, 0, alr, st, i + 1);
      else           add(sel, 0, 0, 0, 1, d, 0, f_unl, f_err, f_alr, f_st, 0);
    end
  endfunction

  function automatic void idle(bit sel, int n, bit unl, bit err, bit alr, int st, int idx);
    for (int i = 0; i < n; i++) add(sel, 0, 0, 0, 0, 0, 0, unl, err, alr, st, idx);
  endfunction

  task automatic drive(input vec_t v);
    ifa.Start = 1'b0; ifa.Mode = 1'b0; ifa.Code_valid = 1'b0; ifa.Code = '0; ifa.Lock = 1'b0;
    ifb.Start = 1'b0; ifb.Mode = 1'b0; ifb.Code_valid = 1'b0; ifb.Code = '0; ifb.Lock = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    if (!v.sel) begin
      rst_a = v.rst; ifa.Start = v.start; ifa.Mode = v.mode;
      ifa.Code_valid = v.cv; ifa.Code = v.code; ifa.Lock = v.lock;
    end else begin
      rst_b = v.rst; ifb.Start = v.start; ifb.Mode = v.mode;
      ifb.Code_valid = v.cv; ifb.Code = v.code[2:0]; ifb.Lock = v.lock;
    end
  endtask

  initial begin
    rst_mark = vecs.size();
    add(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h0103, 0, 0, 1,  1, 0, 0, 3);
    add(0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
      ent(0, 4, 32'h0000, 0, 0, 1,  0, 1, (k == 2), 0);
    end
    idle(0, 2, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0);
    ent(0, 4, 32'h0103, 0, 1, 1,  0, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0);
    ent(0, 4, 32'h0207, 0, 1, 1,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h0103, 0, 0, 1,  1, 0, 0, 3);
    add(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 2, 0);
    ent(0, 4, 32'h9876, 1, 0, 2,  0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h9876, 0, 0, 1,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h0103, 0, 0, 1,  0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h9876, 0, 0, 1,  1, 0, 0, 3);
    add(0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 2);
    idle(0, 15, 0, 0, 0, 1, 2);
    to_mark = vecs.size();
    idle(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h0000, 0, 0, 1,  0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h0000, 0, 0, 1,  0, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0);
    ent(0, 4, 32'h0207, 0, 1, 1,  1, 0, 0, 3);
    add(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 1, 0,  1, 0, 0, 2, 1);
    add(0, 0, 0, 0, 1, 2, 0,  1, 0, 0, 2, 2);
    idle(0, 15, 1, 0, 0, 2, 2);
    idle(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h0103, 0, 0, 1,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 1);
    idle(0, 15, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 1, 3, 0,  1, 0, 0, 3, 0);
    add(0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 5, 0,  1, 0, 0, 2, 1);
    add(0, 0, 0, 0, 1, 5, 0,  1, 0, 0, 2, 2);
    add(0, 1, 1, 0, 1, 5, 1,  0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(0, 4, 32'h0103, 0, 0, 1,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);

    add(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(1, 6, 32'h123456, 0, 0, 1,  1, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    ent(1, 6, 32'h123450, 0, 0, 1,  0, 1, 1, 0);
    add(1, 0, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0);
    ent(1, 6, 32'h123456, 0, 1, 1,  0, 1, 1, 0);
    add(1, 0, 1, 1, 0, 0, 0,  0, 0, 1, 1, 0);
    ent(1, 6, 32'h765432, 0, 1, 1,  1, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      logic       a_unl, a_err, a_alr;
      logic [3:0] a_st;
      logic [2:0] a_idx;
      drive(vecs[i]);
      @(posedge clk);
      #1;
      if (!vecs[i].sel) begin
        a_unl = ifa.Unlock; a_err = ifa.Err; a_alr = ifa.alert;
        a_st = ifa.state_code; a_idx = 3'(ifa.digit_idx);
      end else begin
        a_unl = ifb.Unlock; a_err = ifb.Err; a_alr = ifb.alert;
        a_st = ifb.state_code; a_idx = ifb.digit_idx;
      end
      n_vec++;
      if ({a_unl, a_err, a_alr, a_st, a_idx} !==
          {vecs[i].unl, vecs[i].err, vecs[i].alr, vecs[i].st, vecs[i].idx}) begin
        n_bad++;
        $display("FAIL vec%0d dut%0d: got unl=%0b err=%0b alert=%0b st=%0d idx=%0d, want unl=%0b err=%0b alert=%0b st=%0d idx=%0d",
                 i, vecs[i].sel, a_unl, a_err, a_alr, a_st, a_idx,
                 vecs[i].unl, vecs[i].err, vecs[i].alr, vecs[i].st, vecs[i].idx);
      end
      if (i == rst_mark) begin
        if (ifa.Unlock !== 1'b0 || ifa.Err !== 1'b0 || ifa.alert !== 1'b0 ||
            ifa.state_code !== 4'd0 || ifa.digit_idx !== '0) begin
          n_bad++;
          $display("FAIL reset state: unl=%0b err=%0b alert=%0b st=%0d idx=%0d",
                   ifa.Unlock, ifa.Err, ifa.alert, ifa.state_code, ifa.digit_idx);
        end
      end
      if (i == to_mark) begin
        if (ifa.Err !== 1'b1 || ifa.Unlock !== 1'b0 ||
            ifa.state_code !== 4'd0 || ifa.digit_idx !== '0) begin
          n_bad++;
          $display("FAIL expired wait: unl=%0b err=%0b st=%0d idx=%0d",
                   ifa.Unlock, ifa.Err, ifa.state_code, ifa.digit_idx);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/param_locker.md
# param_locker

Parametrised serial code lock: accepts one code digit per `Code_valid` strobe, checks an N-digit user or admin password, and drives `Unlock`/`Err`/`alert`. It extends the fixed 4-digit locker with configurable digit count, width and retry limit, a strobe handshake, an inactivity timeout, a `Lock` input, and password change gated on a prior unlock. It sits between the keypad/switch debouncer and the LED/7-segment front end.

## Interface
- `DIGITS`, 4: password length; must be ≥ 2.
- `CODE_W`, 4: bits per digit.
- `MAX_TRIES`, 3: consecutive user failures that raise `alert`; must be ≥ 1.
- `TIMEOUT`, 16: idle cycles allowed between digits; 0 disables the timeout.
- `ADMIN_PW`, {0,2,0,7}: admin password, `DIGITS*CODE_W` bits, digit 0 in the MSBs.
- `USER_DEFAULT`, {0,1,0,3}: user password loaded at reset and on admin recovery.
- `CLK` in 1: the single clock.
- `RST` in 1: reset, synchronous and active-high.
- `Code` in CODE_W: digit value, qualified by `Code_valid`.
- `Code_valid` in 1: one-cycle strobe; each high cycle is one digit.
- `Start` in 1: begins an entry sequence.
- `Mode` in 1: sampled with `Start`; 1 = verify, 0 = set a new password.
- `Lock` in 1: relocks from OPEN.
- `Unlock` out 1: door open.
- `Err` out 1: last sequence failed or timed out.
- `alert` out 1: lockout active; only the admin password is accepted.
- `state_code` out 4: encoded state for the 7-segment decoder.
- `digit_idx` out $clog2(DIGITS): index of the next digit expected.

## Operation
- States and `state_code` values: IDLE=0, VERIFY=1, SET=2, OPEN=3.
- IDLE:
  - `Start`&`Mode`=1 → VERIFY. Clear `Err`, `digit_idx`, sticky `mismatch`.
  - `Start`&`Mode`=0 is ignored.
  - `Code_valid` is ignored.
- VERIFY, each accepted digit i:
  - Reference digit is `ADMIN_PW[i]` if `alert` is set, otherwise `user_pw[i]`.
  - Inequality sets `mismatch`.
  - `digit_idx` increments.
- VERIFY verdict, taken on the edge that accepts digit DIGITS-1, with the final digit's compare included:
  - Pass → OPEN, `Unlock`=1, `Err`=0, `fail_cnt`=0. If `alert` was set: clear `alert` and load `user_pw`=`USER_DEFAULT`.
  - Fail, user (`alert`=0) → IDLE, `Err`=1, `fail_cnt`+1. If the new count equals `MAX_TRIES`, set `alert`.
  - Fail, admin (`alert`=1) → IDLE, `Err`=1, `fail_cnt` unchanged (saturates at `MAX_TRIES`).
- OPEN:
  - `Lock` → IDLE, `Unlock`=0.
  - `Start`&`Mode`=0 → SET; `Unlock` stays 1.
  - `Start`&`Mode`=1 is ignored.
  - `Lock` wins over a same-cycle `Start`.
- SET:
  - Each accepted digit is written to a shadow register.
  - On digit DIGITS-1: copy shadow → `user_pw` in one cycle; go to IDLE with `Unlock`=0, `Err`=0.
  - `user_pw` never holds a partial password.
- Timeout:
  - The idle counter clears on entry to VERIFY/SET and on every accepted digit.
  - After `TIMEOUT` consecutive cycles without `Code_valid` in VERIFY or SET: go to IDLE, set `Err`=1, zero `digit_idx`.
  - Timeout in VERIFY counts as a user failure (same `fail_cnt`/`alert` rules as a failed verdict).
  - Timeout in SET discards the shadow and leaves `user_pw` unchanged.
- `fail_cnt` is $clog2(MAX_TRIES+1) bits and saturates.
- `Start` and `Lock` are ignored in VERIFY and SET.
- A `Code_valid` that coincides with a timeout expiry is accepted and clears the idle counter; the digit wins.

## Timing
- All outputs are registered. The verdict is visible on the first cycle after the edge that accepts the last digit.
- One digit per `Code_valid` cycle; back-to-back strobes are accepted every cycle.
- Minimum latency:
  - Verify: 1 (`Start`) + DIGITS cycles.
  - Set from OPEN: 1 + DIGITS cycles.
- `RST` high at any edge, including mid-sequence:
  - Outputs: `Unlock`=0, `Err`=0, `alert`=0, `state_code`=0, `digit_idx`=0.
  - Internal: `fail_cnt`=0, `mismatch`=0, `user_pw`=`USER_DEFAULT`, shadow cleared.
  - `RST` overrides every other input.
- `Err` holds until the next accepted `Start` or reset.

## Test plan
All scenarios use default parameters.
- Correct entry: `Start`/`Mode`=1, digits 0,1,0,3 on consecutive cycles → `Unlock`=1 and `state_code`=3 one cycle after the last digit, `Err`=0.
- Lockout: three wrong entries (0,0,0,0) → `Err`=1 after each; `alert`=1 after the third. Then 0,1,0,3 → `Err`=1, `Unlock`=0.
- Admin recovery: with `alert`=1, enter 0,2,0,7 → `Unlock`=1, `alert`=0. Then `Lock`, then verify 0,1,0,3 → `Unlock`=1 (default password restored).
- Password change: unlock, `Start`/`Mode`=0, digits 9,8,7,6 → IDLE, `Unlock`=0. Verify 9,8,7,6 passes; 0,1,0,3 fails.
- Timeout: verify, enter 0,1, then 16 idle cycles → IDLE, `Err`=1, `fail_cnt`=1. Repeat for SET: `user_pw` is unchanged.
- Edge cases:
  - `RST` asserted after digit 2 of a SET → all outputs 0 and `user_pw`=0103 on the next cycle.
  - `Lock`+`Start` in the same cycle in OPEN → IDLE.
  - Sweep with `DIGITS`=6, `CODE_W`=3.
